// File: rtl/up_controller_vec.sv
// Micro-sequencer for a small accumulator CPU: fetch/execute FSM with
// memory wait/timeout handling and vectored, maskable interrupts.
module up_controller_vec #(
  parameter int N_INT    = 4,  // interrupt lines, 1..8
  parameter int MAX_WAIT = 3,  // memory wait cycles before forced completion, 1..15
  parameter int COND_JMP = 0   // 1: opcode 0111 jumps only when z=1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_INT-1:0] int_req,
  input  logic [N_INT-1:0] int_mask,
  input  logic [3:0]       ir,
  input  logic             z,
  input  logic             mem_rdy,
  output logic [4:0]       op,
  output logic             ir_we,
  output logic             pc_we,
  output logic             rb_we,
  output logic             sp_we,
  output logic             mem_we,
  output logic             z_we,
  output logic             ale,
  output logic [2:0]       rb_sel_in,
  output logic [N_INT-1:0] int_ack,
  output logic [2:0]       int_vec,
  output logic             in_isr,
  output logic             bus_err
);

  localparam logic [2:0] FETCH_LATCH = 3'd0;
  localparam logic [2:0] FETCH_READ  = 3'd1;
  localparam logic [2:0] EXEC_1      = 3'd2;
  localparam logic [2:0] EXEC_2      = 3'd3;
  localparam logic [2:0] EXEC_3      = 3'd4;
  localparam logic [2:0] INT_ACK     = 3'd5;

  localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

  logic [2:0]       r_state;
  logic [3:0]       r_wait_cnt;
  logic             r_in_isr;
  logic             r_global_en;
  logic [N_INT-1:0] r_pending;
  logic [N_INT-1:0] r_int_req_d;

  logic [2:0]       w_state_nxt;
  logic [3:0]       w_wait_nxt;
  logic             w_isr_nxt;
  logic             w_gen_nxt;
  logic [N_INT-1:0] w_ack_clr;
  logic [N_INT-1:0] w_rise;
  logic [2:0]       w_low_idx;
  logic [N_INT-1:0] w_low_onehot;
  logic             w_mem_done;

  assign w_rise     = int_req & ~r_int_req_d & int_mask;
  assign w_mem_done = mem_rdy || (r_wait_cnt == WAIT_MAX);
  assign in_isr     = r_in_isr;

  // Lowest-index pending line wins the acknowledge.
  always_comb begin
    w_low_idx = 3'd0;
    for (int i = N_INT - 1; i >= 0; i--) begin
      if (r_pending[i]) w_low_idx = 3'(i);
    end
    w_low_onehot = (|r_pending) ? (N_INT'(1) << w_low_idx) : '0;
  end

  // Output decode and next-state computation for every FSM state.
  always_comb begin
    // NOTE: every output and next-value is given a default first so no path
    // through the case leaves it unassigned (which would infer a latch).
    op          = {1'b0, ir};
    rb_sel_in   = 3'b100;
    ir_we       = 1'b0;
    pc_we       = 1'b0;
    rb_we       = 1'b0;
    sp_we       = 1'b0;
    mem_we      = 1'b0;
    z_we        = 1'b0;
    ale         = 1'b0;
    int_ack     = '0;
    int_vec     = 3'd0;
    bus_err     = 1'b0;
    w_state_nxt = r_state;
    w_wait_nxt  = r_wait_cnt;
    w_isr_nxt   = r_in_isr;
    w_gen_nxt   = r_global_en;
    w_ack_clr   = '0;

    case (r_state)
      FETCH_LATCH: begin
        if (r_global_en && (|r_pending)) begin
          w_state_nxt = INT_ACK;
        end else begin
          ale         = 1'b1;
          op          = r_in_isr ? 5'b11110 : 5'b11101;
          w_state_nxt = FETCH_READ;
        end
      end

      INT_ACK: begin
        op          = 5'b10000;
        pc_we       = 1'b1;
        int_ack     = w_low_onehot;
        int_vec     = w_low_idx;
        w_ack_clr   = w_low_onehot;
        w_isr_nxt   = 1'b1;
        w_gen_nxt   = 1'b0;
        w_state_nxt = FETCH_LATCH;
      end

      FETCH_READ: begin
        op = 5'b11111;
        if (w_mem_done) begin
          ir_we       = 1'b1;
          pc_we       = 1'b1;
          bus_err     = ~mem_rdy;
          w_wait_nxt  = 4'd0;
          w_state_nxt = EXEC_1;
        end else begin
          w_wait_nxt  = r_wait_cnt + 4'd1;
        end
      end

      EXEC_1: begin
        w_state_nxt = FETCH_LATCH;
        casez (ir)
          4'b00??: begin
            rb_we = 1'b1;
            z_we  = 1'b1;
          end
          4'b0100, 4'b0101, 4'b0110: begin
            rb_sel_in   = {1'b1, ir[1:0]};
            rb_we       = 1'b1;
            w_state_nxt = EXEC_2;
          end
          4'b0111: begin
            rb_sel_in   = 3'b110;
            rb_we       = 1'b1;
            w_state_nxt = EXEC_2;
          end
          4'b100?, 4'b110?: begin
            ale         = 1'b1;
            w_state_nxt = EXEC_2;
          end
          4'b1010: begin
            // Return from interrupt re-enables; otherwise a plain enable toggle.
            if (r_in_isr) begin
              w_isr_nxt = 1'b0;
              w_gen_nxt = 1'b1;
            end else begin
              w_gen_nxt = ~r_global_en;
            end
          end
          4'b1011: rb_we = 1'b1;
          default: ;
        endcase
      end

      EXEC_2: begin
        w_state_nxt = EXEC_3;
        case (ir)
          4'b0100, 4'b0101, 4'b0110: begin
            rb_sel_in = {1'b1, ir[1:0] + 2'd1};
            rb_we     = 1'b1;
          end
          4'b0111: pc_we = (COND_JMP != 0) ? z : 1'b1;
          4'b1000: begin
            rb_sel_in = 3'b010;
            if (w_mem_done) begin
              rb_we       = 1'b1;
              bus_err     = ~mem_rdy;
              w_wait_nxt  = 4'd0;
              w_state_nxt = FETCH_LATCH;
            end else begin
              w_wait_nxt  = r_wait_cnt + 4'd1;
              w_state_nxt = EXEC_2;
            end
          end
          4'b1001: begin
            op          = 5'b11000;
            mem_we      = 1'b1;
            w_state_nxt = FETCH_LATCH;
          end
          4'b1100: begin
            op     = 5'b01000;
            mem_we = 1'b1;
          end
          4'b1101: begin
            rb_sel_in = 3'b011;
            if (w_mem_done) begin
              rb_we      = 1'b1;
              bus_err    = ~mem_rdy;
              w_wait_nxt = 4'd0;
            end else begin
              w_wait_nxt  = r_wait_cnt + 4'd1;
              w_state_nxt = EXEC_2;
            end
          end
          default: ;
        endcase
      end

      EXEC_3: begin
        w_state_nxt = FETCH_LATCH;
        case (ir)
          4'b0100, 4'b0101, 4'b0110: begin
            rb_sel_in = {1'b1, ir[1:0]};
            rb_we     = 1'b1;
          end
          4'b0111: begin
            rb_sel_in = 3'b110;
            rb_we     = 1'b1;
          end
          4'b1100: begin
            op    = 5'b11011;
            sp_we = 1'b1;
          end
          4'b1101: begin
            op    = 5'b11010;
            sp_we = 1'b1;
          end
          default: ;
        endcase
      end

      default: w_state_nxt = FETCH_LATCH;
    endcase

    // While reset is held the outputs look like a plain fetch-latch cycle,
    // so an interrupted wait or acknowledge produces no further strobes.
    if (rst) begin
      op        = 5'b11101;
      ale       = 1'b1;
      rb_sel_in = 3'b100;
      ir_we     = 1'b0;
      pc_we     = 1'b0;
      rb_we     = 1'b0;
      sp_we     = 1'b0;
      mem_we    = 1'b0;
      z_we      = 1'b0;
      int_ack   = '0;
      int_vec   = 3'd0;
      bus_err   = 1'b0;
    end
  end

  // Interrupt edge detection and pending latches; a new edge beats a clear.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      r_int_req_d <= '0;
      r_pending   <= '0;
    end else begin
      r_int_req_d <= int_req;
      r_pending   <= (r_pending & ~w_ack_clr) | w_rise;
    end
  end

  // FSM state, memory wait counter and interrupt enable/service flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= FETCH_LATCH;
      r_wait_cnt  <= 4'd0;
      r_in_isr    <= 1'b0;
      r_global_en <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_wait_cnt  <= w_wait_nxt;
      r_in_isr    <= w_isr_nxt;
      r_global_en <= w_gen_nxt;
    end
  end

endmodule

// File: tb/tb_up_controller_vec.sv
// Directed bench for up_controller_vec: one default instance and one with
// conditional jump enabled, both fed the same stimulus.
module tb_up_controller_vec;

  localparam logic [7:0] S_IRWE = 8'h80;
  localparam logic [7:0] S_PCWE = 8'h40;
  localparam logic [7:0] S_RBWE = 8'h20;
  localparam logic [7:0] S_SPWE = 8'h10;
  localparam logic [7:0] S_MEMW = 8'h08;
  localparam logic [7:0] S_ZWE  = 8'h04;
  localparam logic [7:0] S_ALE  = 8'h02;
  localparam logic [7:0] S_BERR = 8'h01;
  localparam logic [7:0] S_NONE = 8'h00;

  logic       clk;
  logic       rst;
  logic [3:0] int_req;
  logic [3:0] int_mask;
  logic [3:0] ir;
  logic       z;
  logic       mem_rdy;

  logic [4:0] op;
  logic       ir_we, pc_we, rb_we, sp_we, mem_we, z_we, ale, in_isr, bus_err;
  logic [2:0] rb_sel_in, int_vec;
  logic [3:0] int_ack;

  logic [4:0] op_cj;
  logic       ir_we_cj, pc_we_cj, rb_we_cj, sp_we_cj, mem_we_cj, z_we_cj, ale_cj;
  logic       in_isr_cj, bus_err_cj;
  logic [2:0] rb_sel_in_cj, int_vec_cj;
  logic [3:0] int_ack_cj;

  logic [7:0] strb;
  assign strb = {ir_we, pc_we, rb_we, sp_we, mem_we, z_we, ale, bus_err};

  int n_tests = 0;
  int n_fail  = 0;

  up_controller_vec u_dut (
    .clk(clk), .rst(rst), .int_req(int_req), .int_mask(int_mask), .ir(ir), .z(z),
    .mem_rdy(mem_rdy), .op(op), .ir_we(ir_we), .pc_we(pc_we), .rb_we(rb_we),
    .sp_we(sp_we), .mem_we(mem_we), .z_we(z_we), .ale(ale), .rb_sel_in(rb_sel_in),
    .int_ack(int_ack), .int_vec(int_vec), .in_isr(in_isr), .bus_err(bus_err)
  );

  up_controller_vec #(.COND_JMP(1)) u_dut_cj (
    .clk(clk), .rst(rst), .int_req(int_req), .int_mask(int_mask), .ir(ir), .z(z),
    .mem_rdy(mem_rdy), .op(op_cj), .ir_we(ir_we_cj), .pc_we(pc_we_cj), .rb_we(rb_we_cj),
    .sp_we(sp_we_cj), .mem_we(mem_we_cj), .z_we(z_we_cj), .ale(ale_cj),
    .rb_sel_in(rb_sel_in_cj), .int_ack(int_ack_cj), .int_vec(int_vec_cj),
    .in_isr(in_isr_cj), .bus_err(bus_err_cj)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("%s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and let outputs settle away from the edge.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b1; int_req = 4'h0; int_mask = 4'hF; ir = 4'b0111; z = 1'b0; mem_rdy = 1'b1;
    cyc();
    cyc();
    check("rst_strb", strb, S_ALE);
    check("rst_op", op, 5'b11101);
    check("rst_isr", in_isr, 1'b0);
    check("rst_ack", int_ack, 4'h0);

    // Basic ALU loop, three cycles per instruction.
    ir = 4'b0000; rst = 1'b0; #1;
    check("fl_strb", strb, S_ALE);
    check("fl_op", op, 5'b11101);
    cyc(); check("fr_strb", strb, S_IRWE | S_PCWE); check("fr_op", op, 5'b11111);
    cyc(); check("e1_alu_strb", strb, S_RBWE | S_ZWE); check("e1_alu_op", op, 5'b00000);
    check("e1_alu_sel", rb_sel_in, 3'b100);
    cyc(); check("fl2_strb", strb, S_ALE);
    cyc(); check("fr2_strb", strb, S_IRWE | S_PCWE);
    cyc(); check("e1b_strb", strb, S_RBWE | S_ZWE);
    cyc(); check("fl3_strb", strb, S_ALE);

    // Fetch timeout: four cycles, completion and bus error in the last.
    mem_rdy = 1'b0;
    cyc(); check("to_c1", strb, S_NONE); check("to_op", op, 5'b11111);
    cyc(); check("to_c2", strb, S_NONE);
    cyc(); check("to_c3", strb, S_NONE);
    cyc(); check("to_c4", strb, S_IRWE | S_PCWE | S_BERR);
    mem_rdy = 1'b1;
    cyc(); check("to_e1", strb, S_RBWE | S_ZWE);
    cyc(); check("to_fl", strb, S_ALE);

    // Register-bank select sequences.
    ir = 4'b0110;
    cyc(); check("r6_fr", strb, S_IRWE | S_PCWE);
    cyc(); check("r6_e1", rb_sel_in, 3'b110); check("r6_e1_we", strb, S_RBWE);
    cyc(); check("r6_e2", rb_sel_in, 3'b111); check("r6_e2_we", strb, S_RBWE);
    cyc(); check("r6_e3", rb_sel_in, 3'b110); check("r6_e3_we", strb, S_RBWE);
    cyc(); ir = 4'b0100;
    cyc(); check("r4_fr", strb, S_IRWE | S_PCWE);
    cyc(); check("r4_e1", rb_sel_in, 3'b100);
    cyc(); check("r4_e2", rb_sel_in, 3'b101);
    cyc(); check("r4_e3", rb_sel_in, 3'b100);

    // Jump: unconditional on the default instance, z-gated on the other.
    cyc(); ir = 4'b0111; z = 1'b0;
    cyc();
    cyc(); check("j0_e1_sel", rb_sel_in, 3'b110);
    cyc(); check("j0_e2_def", pc_we, 1'b1); check("j0_e2_cj", pc_we_cj, 1'b0);
    cyc(); check("j0_e3_sel", rb_sel_in, 3'b110);
    cyc(); z = 1'b1;
    cyc();
    cyc();
    cyc(); check("j1_e2_cj", pc_we_cj, 1'b1); check("j1_e2_def", pc_we, 1'b1);
    cyc();

    // Pop-like 1101 with one memory wait in EXEC_2.
    cyc(); ir = 4'b1101; z = 1'b0; check("p_fl", strb, S_ALE);
    cyc(); check("p_fr", strb, S_IRWE | S_PCWE);
    cyc(); check("p_e1", strb, S_ALE); check("p_e1_op", op, 5'b01101);
    mem_rdy = 1'b0;
    cyc(); check("p_e2_wait", strb, S_NONE); check("p_e2_sel", rb_sel_in, 3'b011);
    mem_rdy = 1'b1; #1;
    check("p_e2_done", strb, S_RBWE);
    cyc(); check("p_e3", strb, S_SPWE); check("p_e3_op", op, 5'b11010);

    // Push-like 1100.
    cyc(); ir = 4'b1100;
    cyc();
    cyc(); check("s_e1", strb, S_ALE);
    cyc(); check("s_e2", strb, S_MEMW); check("s_e2_op", op, 5'b01000);
    cyc(); check("s_e3", strb, S_SPWE); check("s_e3_op", op, 5'b11011);

    // Store 1001 returns straight to fetch after EXEC_2.
    cyc(); ir = 4'b1001;
    cyc();
    cyc(); check("st_e1", strb, S_ALE);
    cyc(); check("st_e2", strb, S_MEMW); check("st_e2_op", op, 5'b11000);
    cyc(); check("st_fl", strb, S_ALE); check("st_fl_op", op, 5'b11101);

    // Interrupts: enable with 1010, raise lines 1 and 2.
    ir = 4'b1010;
    cyc(); check("ie_fr", strb, S_IRWE | S_PCWE);
    int_req = 4'b0110;
    cyc(); check("ie_e1", strb, S_NONE); check("ie_e1_op", op, 5'b01010);
    cyc(); check("ia_fl", strb, S_NONE);
    cyc(); check("ia1_op", op, 5'b10000); check("ia1_strb", strb, S_PCWE);
    check("ia1_ack", int_ack, 4'b0010); check("ia1_vec", int_vec, 3'd1);
    cyc(); check("isr_fl_op", op, 5'b11110); check("isr_fl_ale", strb, S_ALE);
    check("isr_flag", in_isr, 1'b1); check("isr_ack0", int_ack, 4'h0);
    cyc();
    cyc(); check("reti_e1", strb, S_NONE);
    cyc(); check("reti_isr", in_isr, 1'b0); check("reti_fl", strb, S_NONE);
    cyc(); check("ia2_ack", int_ack, 4'b0100); check("ia2_vec", int_vec, 3'd2);
    cyc(); check("ia2_isr", in_isr, 1'b1); check("ia2_fl_op", op, 5'b11110);

    // Reset in the middle of a fetch wait.
    ir = 4'b0000; mem_rdy = 1'b0;
    cyc(); check("rw_c1", strb, S_NONE);
    cyc(); check("rw_c2", strb, S_NONE);
    rst = 1'b1; #1;
    check("rw_rst_strb", strb, S_ALE); check("rw_rst_op", op, 5'b11101);
    cyc(); check("rw_rst2", strb, S_ALE); check("rw_isr", in_isr, 1'b0);
    rst = 1'b0; mem_rdy = 1'b1; #1;
    check("rw_fl", strb, S_ALE); check("rw_fl_op", op, 5'b11101);
    cyc(); check("rw_fr", strb, S_IRWE | S_PCWE);
    cyc(); check("rw_e1", strb, S_RBWE | S_ZWE);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
